// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel stage.
// master drives the raster outputs and slave samples them.
interface vga_timing_gen_if;
   logic        hsync;
   logic        vsync;
   logic        data_en;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        line_start;
   logic        frame_start;
   logic [7:0]  frame;

   modport master (
      output hsync, vsync, data_en, xpos, ypos, line_start, frame_start, frame
   );

   modport slave (
      input hsync, vsync, data_en, xpos, ypos, line_start, frame_start, frame
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster generator: outputs are registered one cycle after counter state, and the first edge after enable/reset only arms.
// No backpressure; the raster free-runs while enable is high and parks at the origin when it is low.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic              pixclk,
   input  logic              resetn,
   input  logic              enable,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
   localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] H_TOT_END  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE - 1);
   localparam logic [11:0] V_FP_END   = 12'(V_ACTIVE + V_FP - 1);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [11:0] V_TOT_END  = 12'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      SEG_ACTIVE,
      SEG_FP,
      SEG_SYNC,
      SEG_BP
   } seg_t;

   seg_t        h_state;
   seg_t        v_state;
   logic [11:0] hcnt;
   logic [11:0] vcnt;
   logic        running;
   logic        h_wrap;
   logic        v_wrap;
   logic        origin;

   assign h_wrap = (hcnt == H_TOT_END);
   assign v_wrap = (vcnt == V_TOT_END);
   assign origin = (hcnt == 12'd0) && (vcnt == 12'd0);

   // Segment boundaries are the last count of each segment.
   function automatic seg_t next_seg(input seg_t s, input logic [11:0] c,
                                     input logic [11:0] e_act, input logic [11:0] e_fp,
                                     input logic [11:0] e_sync, input logic [11:0] e_tot);
      seg_t n;
      n = s;
      case (s)
         SEG_ACTIVE: if (c == e_act)  n = SEG_FP;
         SEG_FP:     if (c == e_fp)   n = SEG_SYNC;
         SEG_SYNC:   if (c == e_sync) n = SEG_BP;
         SEG_BP:     if (c == e_tot)  n = SEG_ACTIVE;
         default:    n = SEG_ACTIVE;
      endcase
      return n;
   endfunction

   always_ff @(posedge pixclk or negedge resetn) begin
      if (!resetn) begin
         h_state         <= SEG_ACTIVE;
         v_state         <= SEG_ACTIVE;
         hcnt            <= 12'd0;
         vcnt            <= 12'd0;
         running         <= 1'b0;
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
         vga.data_en     <= 1'b0;
         vga.xpos        <= 12'd0;
         vga.ypos        <= 12'd0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
         vga.frame       <= 8'd0;
      end else if (!enable) begin
         // Park at the origin; frame count survives a disable.
         h_state         <= SEG_ACTIVE;
         v_state         <= SEG_ACTIVE;
         hcnt            <= 12'd0;
         vcnt            <= 12'd0;
         running         <= 1'b0;
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
         vga.data_en     <= 1'b0;
         vga.xpos        <= 12'd0;
         vga.ypos        <= 12'd0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else if (!running) begin
         running <= 1'b1;
      end else begin
         vga.data_en     <= (h_state == SEG_ACTIVE) && (v_state == SEG_ACTIVE);
         vga.hsync       <= (h_state == SEG_SYNC) ? HS_POL : ~HS_POL;
         vga.vsync       <= (v_state == SEG_SYNC) ? VS_POL : ~VS_POL;
         vga.line_start  <= (hcnt == 12'd0);
         vga.frame_start <= origin;
         if ((h_state == SEG_ACTIVE) && (v_state == SEG_ACTIVE)) begin
            vga.xpos <= hcnt;
            vga.ypos <= vcnt;
         end
         if (origin) begin
            vga.frame <= vga.frame + 8'd1;
         end
         h_state <= next_seg(h_state, hcnt, H_ACT_END, H_FP_END, H_SYNC_END, H_TOT_END);
         hcnt    <= h_wrap ? 12'd0 : hcnt + 12'd1;
         if (h_wrap) begin
            v_state <= next_seg(v_state, vcnt, V_ACT_END, V_FP_END, V_SYNC_END, V_TOT_END);
            vcnt    <= v_wrap ? 12'd0 : vcnt + 12'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three raster instances (default, small inverted-polarity, small-line/default-frame) checked against a cycle model scoreboard.
module tb_vga_timing_gen;

   typedef struct packed {
      logic        hsync;
      logic        vsync;
      logic        de;
      logic [11:0] xpos;
      logic [11:0] ypos;
      logic        ls;
      logic        fs;
      logic [7:0]  frame;
   } out_t;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb;
      bit hp, vp;
   } cfg_t;

   typedef struct {
      bit   run;
      int   h;
      int   v;
      out_t o;
   } mst_t;

   logic       pixclk = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] en     = 3'b000;
   int         total  = 0;
   int         bad    = 0;

   cfg_t cfgs [3];
   mst_t ms   [3];
   out_t sb   [3][$];
   out_t obs  [3];

   always #5 pixclk = ~pixclk;

   vga_timing_gen_if vif0 ();
   vga_timing_gen_if vif1 ();
   vga_timing_gen_if vif2 ();

   vga_timing_gen dut0 (
      .pixclk (pixclk), .resetn (resetn), .enable (en[0]), .vga (vif0)
   );

   vga_timing_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL (1'b0), .VS_POL (1'b0)
   ) dut1 (
      .pixclk (pixclk), .resetn (resetn), .enable (en[1]), .vga (vif1)
   );

   vga_timing_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1)
   ) dut2 (
      .pixclk (pixclk), .resetn (resetn), .enable (en[2]), .vga (vif2)
   );

   assign obs[0] = {vif0.hsync, vif0.vsync, vif0.data_en, vif0.xpos, vif0.ypos,
                    vif0.line_start, vif0.frame_start, vif0.frame};
   assign obs[1] = {vif1.hsync, vif1.vsync, vif1.data_en, vif1.xpos, vif1.ypos,
                    vif1.line_start, vif1.frame_start, vif1.frame};
   assign obs[2] = {vif2.hsync, vif2.vsync, vif2.data_en, vif2.xpos, vif2.ypos,
                    vif2.line_start, vif2.frame_start, vif2.frame};

   function automatic out_t idle_out(input cfg_t c, input logic [7:0] fr);
      out_t o;
      o       = '0;
      o.hsync = !c.hp;
      o.vsync = !c.vp;
      o.frame = fr;
      return o;
   endfunction

   function automatic mst_t reset_state(input cfg_t c);
      mst_t s;
      s.run = 1'b0;
      s.h   = 0;
      s.v   = 0;
      s.o   = idle_out(c, 8'd0);
      return s;
   endfunction

   // Expected outputs for the next edge, derived from the raster ranges.
   function automatic mst_t model_step(input cfg_t c, input mst_t s, input bit ena);
      mst_t n;
      int   ht, vt;
      n  = s;
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      if (!ena) begin
         n.run = 1'b0;
         n.h   = 0;
         n.v   = 0;
         n.o   = idle_out(c, s.o.frame);
      end else if (!s.run) begin
         n.run = 1'b1;
      end else begin
         n.o.de    = (s.h < c.ha) && (s.v < c.va);
         n.o.hsync = (s.h >= c.ha + c.hf && s.h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
         n.o.vsync = (s.v >= c.va + c.vf && s.v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
         if (n.o.de) begin
            n.o.xpos = 12'(s.h);
            n.o.ypos = 12'(s.v);
         end
         n.o.ls = (s.h == 0);
         n.o.fs = (s.h == 0) && (s.v == 0);
         if (n.o.fs) n.o.frame = s.o.frame + 8'd1;
         if (s.h == ht - 1) begin
            n.h = 0;
            n.v = (s.v == vt - 1) ? 0 : s.v + 1;
         end else begin
            n.h = s.h + 1;
         end
      end
      return n;
   endfunction

   task automatic tick(input int k);
      for (int j = 0; j < 3; j++) ms[j] = model_step(cfgs[j], ms[j], en[j]);
      sb[k].push_back(ms[k].o);
      @(posedge pixclk);
      #1;
   endtask

   task automatic reset_models();
      for (int j = 0; j < 3; j++) begin
         ms[j] = reset_state(cfgs[j]);
         sb[j].delete();
      end
   endtask

   task automatic test_reset();
      out_t e;
      resetn = 1'b0;
      en     = 3'b001;
      repeat (3) @(posedge pixclk);
      #1;
      for (int k = 0; k < 3; k++) begin
         e = idle_out(cfgs[k], 8'd0);
         total++;
         if (obs[k] !== e) begin
            bad++;
            $display("FAIL reset_idle inst=%0d got=%h exp=%h", k, obs[k], e);
         end
      end
      reset_models();
      resetn = 1'b1;
   endtask

   task automatic test_default_line();
      out_t        e;
      int          ls0 = -1, ls1 = -1, rise0 = -1, fall0 = -1, de_cnt = 0;
      logic [11:0] last_x = '0;
      logic        prev_hs;
      en[0]   = 1'b1;
      prev_hs = obs[0].hsync;
      for (int i = 0; i < 2600; i++) begin
         tick(0);
         e = sb[0].pop_front();
         total++;
         if (obs[0] !== e) begin
            bad++;
            $display("FAIL default_sb cyc=%0d got=%h exp=%h", i, obs[0], e);
            break;
         end
         if (i == 0) begin
            total++;
            if ({obs[0].de, obs[0].ls, obs[0].fs} !== 3'b000) begin
               bad++;
               $display("FAIL first_edge_idle got=%b exp=000", {obs[0].de, obs[0].ls, obs[0].fs});
            end
         end
         if (i == 1) begin
            total++;
            if ({obs[0].de, obs[0].xpos, obs[0].ls, obs[0].fs, obs[0].frame} !==
                {1'b1, 12'd0, 1'b1, 1'b1, 8'd1}) begin
               bad++;
               $display("FAIL second_edge_origin got de=%b x=%0d ls=%b fs=%b fr=%0d exp 1,0,1,1,1",
                        obs[0].de, obs[0].xpos, obs[0].ls, obs[0].fs, obs[0].frame);
            end
         end
         if (obs[0].ls) begin
            if (ls0 < 0) ls0 = i;
            else if (ls1 < 0) ls1 = i;
         end
         if (obs[0].hsync && !prev_hs && rise0 < 0) rise0 = i;
         if (!obs[0].hsync && prev_hs && rise0 >= 0 && fall0 < 0) fall0 = i;
         if (obs[0].de && i <= 800) begin
            de_cnt++;
            last_x = obs[0].xpos;
         end
         prev_hs = obs[0].hsync;
      end
      total++;
      if (de_cnt !== 640) begin bad++; $display("FAIL de_width got=%0d exp=640", de_cnt); end
      total++;
      if (last_x !== 12'd639) begin bad++; $display("FAIL last_xpos got=%0d exp=639", last_x); end
      total++;
      if (rise0 - ls0 !== 656) begin bad++; $display("FAIL hsync_offset got=%0d exp=656", rise0 - ls0); end
      total++;
      if (fall0 - rise0 !== 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", fall0 - rise0); end
      total++;
      if (ls1 - ls0 !== 800) begin bad++; $display("FAIL line_period got=%0d exp=800", ls1 - ls0); end
      en[0] = 1'b0;
      tick(0);
      e = sb[0].pop_front();
      total++;
      if (obs[0] !== e) begin bad++; $display("FAIL default_park got=%h exp=%h", obs[0], e); end
   endtask

   task automatic test_small_raster();
      out_t        e;
      int          ls0 = -1, ls1 = -1, fs0 = -1, fs1 = -1, nfs = 0, pos = 0, line = 0, nxs = 0;
      logic [7:0]  hs_mask = '0;
      logic [4:0]  vs_mask = '0;
      logic [47:0] xs = '0;
      logic [47:0] xs_exp;
      en[1]  = 1'b1;
      xs_exp = {12'd0, 12'd1, 12'd2, 12'd3};
      for (int i = 0; i < 120; i++) begin
         tick(1);
         e = sb[1].pop_front();
         total++;
         if (obs[1] !== e) begin
            bad++;
            $display("FAIL small_sb cyc=%0d got=%h exp=%h", i, obs[1], e);
            break;
         end
         if (obs[1].fs) begin
            nfs++;
            if (nfs == 1) fs0 = i;
            if (nfs == 2) fs1 = i;
            line = 0;
         end else if (obs[1].ls) begin
            line++;
         end
         if (obs[1].ls) begin
            pos = 0;
            if (ls0 < 0) ls0 = i;
            else if (ls1 < 0) ls1 = i;
         end else begin
            pos++;
         end
         if (nfs == 1 && line == 0 && pos < 8 && !obs[1].hsync) hs_mask[pos] = 1'b1;
         if (nfs == 1 && obs[1].ls && line < 5 && !obs[1].vsync) vs_mask[line] = 1'b1;
         if (nfs == 1 && line == 0 && obs[1].de) begin
            xs = {xs[35:0], obs[1].xpos};
            nxs++;
         end
      end
      total++;
      if (ls1 - ls0 !== 8) begin bad++; $display("FAIL small_line_period got=%0d exp=8", ls1 - ls0); end
      total++;
      if (fs1 - fs0 !== 40) begin bad++; $display("FAIL small_frame_period got=%0d exp=40", fs1 - fs0); end
      total++;
      if (hs_mask !== 8'h60) begin bad++; $display("FAIL small_hsync_low got=%h exp=60", hs_mask); end
      total++;
      if (vs_mask !== 5'h08) begin bad++; $display("FAIL small_vsync_low got=%h exp=08", vs_mask); end
      total++;
      if (nxs !== 4 || xs !== xs_exp) begin
         bad++;
         $display("FAIL small_xpos_seq got=%h n=%0d exp=%h n=4", xs, nxs, xs_exp);
      end
      en[1] = 1'b0;
      tick(1);
      e = sb[1].pop_front();
      total++;
      if (obs[1] !== e) begin bad++; $display("FAIL small_park got=%h exp=%h", obs[1], e); end
   endtask

   task automatic test_vsync();
      out_t e;
      int   nfs = 0, fs0 = -1, fs1 = -1, line = -1, vs_first = -1, vs_lines = 0;
      int   de_bad = 0, vs_odd = 0;
      logic prev_vs;
      en[2]   = 1'b1;
      prev_vs = obs[2].vsync;
      for (int i = 0; i < 8700; i++) begin
         tick(2);
         e = sb[2].pop_front();
         total++;
         if (obs[2] !== e) begin
            bad++;
            $display("FAIL vsync_sb cyc=%0d got=%h exp=%h", i, obs[2], e);
            break;
         end
         if (obs[2].fs) begin
            nfs++;
            if (nfs == 1) fs0 = i;
            if (nfs == 2) fs1 = i;
            line = 0;
         end else if (obs[2].ls && line >= 0) begin
            line++;
         end
         if (obs[2].ls && nfs == 1 && obs[2].vsync) begin
            vs_lines++;
            if (vs_first < 0) vs_first = line;
         end
         if (obs[2].vsync !== prev_vs && !obs[2].ls) vs_odd++;
         if (obs[2].de && obs[2].ypos >= 12'd480) de_bad++;
         prev_vs = obs[2].vsync;
      end
      total++;
      if (vs_first !== 490) begin bad++; $display("FAIL vsync_first_line got=%0d exp=490", vs_first); end
      total++;
      if (vs_lines !== 2) begin bad++; $display("FAIL vsync_lines got=%0d exp=2", vs_lines); end
      total++;
      if (fs1 - fs0 !== 4200) begin bad++; $display("FAIL frame_period got=%0d exp=4200", fs1 - fs0); end
      total++;
      if (de_bad !== 0) begin bad++; $display("FAIL de_in_vblank got=%0d exp=0", de_bad); end
      total++;
      if (vs_odd !== 0) begin bad++; $display("FAIL vsync_midline_edges got=%0d exp=0", vs_odd); end
   endtask

   task automatic test_enable_drop(input int k, input bit need_vs);
      out_t       e;
      bit         found = 1'b0;
      logic [7:0] fr = '0;
      en[k] = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         tick(k);
         e = sb[k].pop_front();
         total++;
         if (obs[k] !== e) begin
            bad++;
            $display("FAIL drop_run_sb inst=%0d cyc=%0d got=%h exp=%h", k, i, obs[k], e);
            break;
         end
         if (obs[k].hsync == cfgs[k].hp && (!need_vs || obs[k].vsync == cfgs[k].vp)) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (found !== 1'b1) begin bad++; $display("FAIL drop_sync_reached inst=%0d got=0 exp=1", k); end
      fr    = obs[k].frame;
      en[k] = 1'b0;
      tick(k);
      e = sb[k].pop_front();
      total++;
      if (obs[k] !== e) begin bad++; $display("FAIL drop_sb inst=%0d got=%h exp=%h", k, obs[k], e); end
      total++;
      if ({obs[k].hsync, obs[k].vsync, obs[k].de, obs[k].ls, obs[k].fs, obs[k].frame} !==
          {!cfgs[k].hp, !cfgs[k].vp, 3'b000, fr}) begin
         bad++;
         $display("FAIL drop_idle inst=%0d got hs=%b vs=%b de=%b fr=%0d exp hs=%b vs=%b de=0 fr=%0d",
                  k, obs[k].hsync, obs[k].vsync, obs[k].de, obs[k].frame, !cfgs[k].hp, !cfgs[k].vp, fr);
      end
      repeat (3) begin
         tick(k);
         e = sb[k].pop_front();
         total++;
         if (obs[k] !== e) begin bad++; $display("FAIL parked_sb inst=%0d got=%h exp=%h", k, obs[k], e); end
      end
      en[k] = 1'b1;
      tick(k);
      e = sb[k].pop_front();
      total++;
      if (obs[k] !== e) begin bad++; $display("FAIL reen1_sb inst=%0d got=%h exp=%h", k, obs[k], e); end
      total++;
      if ({obs[k].de, obs[k].fs} !== 2'b00) begin
         bad++;
         $display("FAIL reen_first_edge inst=%0d got=%b exp=00", k, {obs[k].de, obs[k].fs});
      end
      tick(k);
      e = sb[k].pop_front();
      total++;
      if (obs[k] !== e) begin bad++; $display("FAIL reen2_sb inst=%0d got=%h exp=%h", k, obs[k], e); end
      total++;
      if ({obs[k].de, obs[k].xpos, obs[k].ypos, obs[k].ls, obs[k].fs, obs[k].frame} !==
          {1'b1, 24'd0, 2'b11, 8'(fr + 8'd1)}) begin
         bad++;
         $display("FAIL reen_origin inst=%0d got de=%b x=%0d y=%0d fs=%b fr=%0d exp 1,0,0,1,%0d",
                  k, obs[k].de, obs[k].xpos, obs[k].ypos, obs[k].fs, obs[k].frame, 8'(fr + 8'd1));
      end
      en[k] = 1'b0;
      tick(k);
      e = sb[k].pop_front();
      total++;
      if (obs[k] !== e) begin bad++; $display("FAIL drop_end_sb inst=%0d got=%h exp=%h", k, obs[k], e); end
   endtask

   task automatic test_async_reset();
      out_t e;
      en[1] = 1'b1;
      for (int i = 0; i < 57; i++) begin
         tick(1);
         e = sb[1].pop_front();
         total++;
         if (obs[1] !== e) begin
            bad++;
            $display("FAIL areset_run_sb cyc=%0d got=%h exp=%h", i, obs[1], e);
            break;
         end
      end
      #3;
      resetn = 1'b0;
      #1;
      e = idle_out(cfgs[1], 8'd0);
      total++;
      if (obs[1] !== e) begin bad++; $display("FAIL areset_immediate got=%h exp=%h", obs[1], e); end
      reset_models();
      @(posedge pixclk);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         e = sb[1].pop_front();
         total++;
         if (obs[1] !== e) begin bad++; $display("FAIL areset_restart_sb cyc=%0d got=%h exp=%h", i, obs[1], e); end
      end
      total++;
      if ({obs[1].fs, obs[1].frame} !== {1'b1, 8'd1}) begin
         bad++;
         $display("FAIL areset_first_frame got fs=%b fr=%0d exp fs=1 fr=1", obs[1].fs, obs[1].frame);
      end
   endtask

   task automatic test_frame_wrap();
      out_t       e;
      int         nfs = 0, wrap_at = -1, glitch = 0;
      logic [7:0] prev_fr;
      resetn = 1'b0;
      reset_models();
      en[1] = 1'b1;
      #2;
      resetn  = 1'b1;
      @(posedge pixclk);
      #1;
      ms[1]   = model_step(cfgs[1], ms[1], 1'b1);
      ms[0]   = model_step(cfgs[0], ms[0], en[0]);
      ms[2]   = model_step(cfgs[2], ms[2], en[2]);
      prev_fr = obs[1].frame;
      for (int i = 0; i < 10400; i++) begin
         tick(1);
         e = sb[1].pop_front();
         total++;
         if (obs[1] !== e) begin
            bad++;
            $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", i, obs[1], e);
            break;
         end
         if (obs[1].fs) nfs++;
         if (obs[1].frame !== prev_fr && !obs[1].fs) glitch++;
         if (obs[1].fs && obs[1].frame == 8'd0 && prev_fr == 8'd255 && wrap_at < 0) wrap_at = nfs;
         prev_fr = obs[1].frame;
         if (wrap_at >= 0 && nfs >= 257) break;
      end
      total++;
      if (wrap_at !== 256) begin bad++; $display("FAIL frame_wrap_at got=%0d exp=256", wrap_at); end
      total++;
      if (glitch !== 0) begin bad++; $display("FAIL frame_glitch got=%0d exp=0", glitch); end
      en[1] = 1'b0;
   endtask

   initial begin
      cfgs[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b1, vp: 1'b1};
      cfgs[1] = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 2, vf: 1, vs: 1, vb: 1, hp: 1'b0, vp: 1'b0};
      cfgs[2] = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b1, vp: 1'b1};
      test_reset();
      test_default_line();
      test_enable_drop(0, 1'b0);
      test_small_raster();
      test_async_reset();
      en[1] = 1'b0;
      tick(1);
      void'(sb[1].pop_front());
      test_vsync();
      test_enable_drop(2, 1'b1);
      test_frame_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the picosoc VGA path; sits directly upstream of the text/cursor pixel stage.
Runs entirely in the pixclk domain and produces hsync, vsync, data_en plus pixel coordinates and frame/line markers.
The pixel stage consumes these signals and rising-edge-detects hsync/vsync, which makes sync polarity a parameter.
Default timing is 640x480@60 (800x525 total, 25.175 MHz nominal pixclk).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync

Ports:
pixclk  in  1  pixel clock; the only clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  run when 1; when 0, raster parks at origin with outputs idle
hsync  out  1  horizontal sync, asserted level HS_POL
vsync  out  1  vertical sync, asserted level VS_POL
data_en  out  1  high for visible pixels
xpos  out  12  column of current pixel, valid while data_en
ypos  out  12  line of current pixel, valid while data_en
line_start  out  1  one-cycle pulse on first pixel of every line (hcnt==0)
frame_start  out  1  one-cycle pulse on first pixel of frame (hcnt==0, vcnt==0)
frame  out  8  frame counter, increments with frame_start

Behaviour:
- Reset (resetn=0, async): hcnt=vcnt=0, both FSMs in ACTIVE, hsync=~HS_POL, vsync=~VS_POL, data_en=0, xpos=ypos=0, line_start=frame_start=0, frame=0.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Both totals must be <= 4096 and every parameter >= 1.
- Horizontal FSM ACTIVE->FP->SYNC->BP->ACTIVE.
  - Segment lengths: H_ACTIVE, H_FP, H_SYNC, H_BP pixels.
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
- Vertical FSM ACTIVE->FP->SYNC->BP->ACTIVE.
  - Advances only on the cycle hcnt wraps (H_TOTAL-1 -> 0).
  - vcnt wraps V_TOTAL-1 -> 0 on the same cycle.
- Outputs are registered, one cycle of latency from counter state. With counters at (h,v) on edge N, edge N+1 presents:
  - data_en = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync = VS_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync changes only at line boundaries.
  - xpos = h, ypos = v while data_en; both hold their last value otherwise.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- frame increments by 1 in the cycle frame_start is presented; 8-bit, wraps 255->0.
- enable=0 (sampled synchronously):
  - Next edge forces hcnt=vcnt=0, FSMs to ACTIVE, outputs to their reset values.
  - frame holds its value.
- enable 0->1: first edge presents nothing new; the second edge presents data_en=1, xpos=0, ypos=0, line_start=1, frame_start=1.
- enable dropped mid-line or mid-sync: idle the next cycle, no partial pulse stretching. Restart always begins at the origin.
- Async reset mid-frame: immediate idle values. First frame after release behaves as the enable 0->1 case.
- Simultaneous h-wrap and v-wrap: a single edge yields hcnt=0, vcnt=0.

Test Plan:
- Reset release with enable=1, defaults:
  - cycle 2: data_en=1, xpos=0, line_start=1, frame_start=1, frame=1.
  - data_en stays high 640 cycles (xpos 0..639), then low for 160.
- hsync timing, defaults: after line_start, hsync rises (HS_POL=1) exactly 656 cycles later, stays high 96 cycles, and line_start recurs every 800 cycles.
- vsync timing: vsync asserted for exactly 2 lines, starting on line 490. frame_start period is 420000 cycles. data_en never high with ypos>=480.
- Polarity/small raster with H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=0:
  - line 8 cycles, frame 40 cycles.
  - hsync low on h=5,6; vsync low on v=3.
  - xpos sequence 0,1,2,3.
- Run-time enable: drop enable at h=700, v=491 (in vsync).
  - Next cycle hsync/vsync inactive, data_en=0, frame unchanged.
  - Re-enable: frame_start on second edge, frame+1.
- Frame wrap: run 256 frames on the small raster; frame goes 255->0 on the 256th frame_start, with no glitch on other outputs.
